psum_drain: RTL and testbench
=============================

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, psum buffer address width.
REQ-002 SHALL have parameter LANES, default 4, output channels per buffer word.
REQ-003 SHALL have parameter PSUM_W, default 40, signed partial-sum width per lane.
REQ-004 SHALL have parameter OUT_W, default 16, signed output width per lane.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to drain one tile.
REQ-008 SHALL have port base_addr, input, ADDR_W, first buffer address of the tile.
REQ-009 SHALL have port tile_size, input, 8, word count minus 1.
REQ-010 SHALL have port shift, input, 6, right-shift amount, 0..39.
REQ-011 SHALL have ports re (output, 1), ra (output, ADDR_W) and rd (input, LANES*PSUM_W) forming the psum buffer read port.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, LANES*OUT_W) forming the result stream; lane k occupies bits [OUT_W*k +: OUT_W].
REQ-013 SHALL have ports busy (output, 1) and done (output, 1); done is a one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, DRAIN, FLUSH; start is sampled only in IDLE and ignored otherwise.
REQ-015 On start in IDLE, SHALL latch base_addr, tile_size and shift, clear the issue counter i, enter DRAIN and assert busy from the next cycle.
REQ-016 In DRAIN, SHALL assert re with ra=(base_addr+i) mod 2^ADDR_W only when FIFO occupancy plus in-flight reads is less than 2; i increments on each issue.
REQ-017 After issuing i=tile_size, SHALL enter FLUSH.
REQ-018 SHALL treat rd as valid exactly one cycle after re.
REQ-019 SHALL quantize each rd lane and push the result into a 2-entry output FIFO in that same cycle; the FIFO never overflows.
REQ-020 Per-lane quantization SHALL be: a signed 40-bit value v; if shift>0, add 2^(shift-1) rounding; arithmetic right shift by shift; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 out_valid SHALL equal "FIFO not empty", with out_data at the FIFO head.
REQ-022 A beat transfers when out_valid && out_ready.
REQ-023 out_data SHALL hold stable while out_valid && !out_ready.
REQ-024 With out_ready held high, start at cycle 0 SHALL produce re at cycle 1 and out_valid at cycle 3, then one beat per cycle with no bubbles.
REQ-025 In FLUSH, SHALL pulse done and return to IDLE in the cycle after the final beat (index tile_size) transfers; busy deasserts together with done.
REQ-026 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-027 tile_size=0 SHALL drain exactly one word.
REQ-028 tile_size=255 SHALL drain 256 words, with ra wrapping modulo 2^ADDR_W.

Reset
REQ-029 rst SHALL force IDLE, clear the FIFO and the in-flight read, and drive re=0, ra=0, out_valid=0, out_data=0, busy=0 and done=0, including when asserted mid-drain; no beat of an aborted tile is emitted afterward.

Configuration
REQ-030 With PSUM_DRAIN_RELU_EN defined, SHALL clamp negative lane values to 0 before rounding; without the macro, signed values pass to saturation unchanged.

Structure
REQ-031 SHALL take ADDR_W, LANES, PSUM_W and OUT_W defaults and the state encoding from shared package fsrcnn_pkg.
REQ-032 SHALL contain one combinational sub-module, psum_quant, which performs the per-lane ReLU/round/shift/saturate and is instantiated LANES times.

Verification
REQ-033 base=0x10, tile_size=3, shift=8, out_ready=1, rd lane0=0x0000001280 -> ra 0x10..0x13 on cycles 1..4; lane0 out=0x0013; done at cycle 7.
REQ-034 Lane value 0x7FFFFFFFFF with shift=4 -> 0x7FFF; lane value -2^39 -> 0x8000, or 0x0000 with PSUM_DRAIN_RELU_EN.
REQ-035 out_ready low for cycles 3..10 -> at most 2 reads outstanding, out_data stable, no lost or duplicated beats, in-order completion.
REQ-036 base=0xFE, tile_size=3 -> ra sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-037 rst asserted after the 2nd beat of a 10-word tile -> all outputs 0 next cycle; a new start then drains correctly from its own base_addr.
REQ-038 start pulsed while busy -> ignored; exactly tile_size+1 beats and a single done pulse.

Source files
------------

// File: rtl/fsrcnn_pkg.sv
// Shared defaults and FSM state encoding for the FSRCNN accelerator datapath blocks.
package fsrcnn_pkg;

  localparam int unsigned PSUM_ADDR_W = 8;
  localparam int unsigned PSUM_LANES  = 4;
  localparam int unsigned PSUM_W_DEF  = 40;
  localparam int unsigned OUT_W_DEF   = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/psum_quant.sv
// Per-lane requantization: optional ReLU, round-half-up, arithmetic right shift, saturate.
// ReLU is compiled in when PSUM_DRAIN_RELU_EN is defined.
module psum_quant #(
  parameter int unsigned PSUM_W = 40,
  parameter int unsigned OUT_W  = 16
) (
  input  logic [PSUM_W-1:0] psum_i,
  input  logic [5:0]        shift_i,
  output logic [OUT_W-1:0]  quant_c
);

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  localparam int unsigned EXT_W = PSUM_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shd;

  always_comb begin
    ext = {psum_i[PSUM_W-1], psum_i};
`ifdef PSUM_DRAIN_RELU_EN
    if (psum_i[PSUM_W-1]) begin
      ext = '0;
    end
`endif
    rnd = ext;
    if (shift_i != 6'd0) begin
      rnd = ext + (EXT_W'(1) << (shift_i - 6'd1));
    end
    shd = rnd >>> shift_i;
    quant_c = shd[OUT_W-1:0];
    if (shd > MAX_V) begin
      quant_c = MAX_V[OUT_W-1:0];
    end else if (shd < MIN_V) begin
      quant_c = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Drains one tile of partial sums from the psum buffer, requantizes every lane and streams the words out.
// Define PSUM_DRAIN_RELU_EN to clamp negative partial sums to zero before requantization.
module psum_drain
  import fsrcnn_pkg::*;
#(
  parameter int unsigned ADDR_W = PSUM_ADDR_W,
  parameter int unsigned LANES  = PSUM_LANES,
  parameter int unsigned PSUM_W = PSUM_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [7:0]              tile_size,
  input  logic [5:0]              shift,
  output logic                    re,
  output logic [ADDR_W-1:0]       ra,
  input  logic [LANES*PSUM_W-1:0] rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned WORD_W = LANES * OUT_W;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tile_q, tile_d;
  logic [7:0]        issue_q, issue_d;
  logic [7:0]        beat_q, beat_d;
  logic [5:0]        shift_q, shift_d;
  logic              done_q, done_d;
  logic              rd_vld_q;
  logic [WORD_W-1:0] fifo_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] quant_word;
  logic              issue;
  logic              pop;
  logic [2:0]        outstanding;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    psum_quant #(
      .PSUM_W (PSUM_W),
      .OUT_W  (OUT_W)
    ) u_quant (
      .psum_i  (rd[PSUM_W*k +: PSUM_W]),
      .shift_i (shift_q),
      .quant_c (quant_word[OUT_W*k +: OUT_W])
    );
  end

  // Next-state and read-issue logic; a read is issued only if it cannot overflow the FIFO.
  always_comb begin
    pop         = (cnt_q != 2'd0) && out_ready;
    outstanding = 3'(cnt_q) - 3'(pop) + 3'(rd_vld_q);
    issue       = (state_q == ST_DRAIN) && (outstanding < 3'd2);
    state_d     = state_q;
    addr_d      = addr_q;
    tile_d      = tile_q;
    issue_d     = issue_q;
    beat_d      = beat_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q + 2'(rd_vld_q) - 2'(pop);
    wr_ptr_d    = wr_ptr_q ^ rd_vld_q;
    rd_ptr_d    = rd_ptr_q ^ pop;
    if (pop) begin
      beat_d = beat_q + 8'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRAIN;
          addr_d  = base_addr;
          tile_d  = tile_size;
          shift_d = shift;
          issue_d = 8'd0;
          beat_d  = 8'd0;
        end
      end
      ST_DRAIN: begin
        if (issue) begin
          addr_d  = addr_q + ADDR_W'(1);
          issue_d = issue_q + 8'd1;
          if (issue_q == tile_q) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (pop && (beat_q == tile_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      tile_q    <= '0;
      issue_q   <= '0;
      beat_q    <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tile_q   <= tile_d;
      issue_q  <= issue_d;
      beat_q   <= beat_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
      rd_vld_q <= issue;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (rd_vld_q) begin
        fifo_q[wr_ptr_q] <= quant_word;
      end
    end
  end

  assign re        = issue;
  assign ra        = issue ? addr_q : '0;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: a behavioural psum buffer plus a 64-bit requantization model.
module tb_psum_drain;

  localparam int ADDR_W = 8;
  localparam int LANES  = 4;
  localparam int PSUM_W = 40;
  localparam int OUT_W  = 16;
  localparam longint QMAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam longint QMIN = -QMAX - 64'sd1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [7:0]              tile_size = '0;
  logic [5:0]              shift = '0;
  logic                    re;
  logic [ADDR_W-1:0]       ra;
  logic [LANES*PSUM_W-1:0] rd = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [LANES*OUT_W-1:0]  out_data;
  logic                    busy;
  logic                    done;

  psum_drain #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .PSUM_W (PSUM_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .tile_size (tile_size),
    .shift     (shift),
    .re        (re),
    .ra        (ra),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;

  logic [LANES*PSUM_W-1:0] mem [256];
  logic [LANES*PSUM_W-1:0] junk = {LANES{40'h5A5A5A5A5A}};

  logic [ADDR_W-1:0]      exp_ra[$], obs_ra[$];
  logic [LANES*OUT_W-1:0] exp_beat[$], obs_beat[$];
  int obs_ra_cyc[$], obs_beat_cyc[$];
  int done_cnt = 0, done_cyc = 0, os = 0, max_os = 0, stable_viol = 0;
  logic busy_at_done = 1'b0;
  logic held_vld = 1'b0;
  logic [LANES*OUT_W-1:0] held_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Psum buffer: data appears the cycle after the read enable.
  always @(posedge clk) rd <= re ? mem[ra] : junk;

  // Observer: records reads, beats, done pulses, outstanding depth and hold violations.
  always @(negedge clk) begin
    if (re) begin obs_ra.push_back(ra); obs_ra_cyc.push_back(cyc); end
    if (out_valid && out_ready) begin obs_beat.push_back(out_data); obs_beat_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if (held_vld && (!out_valid || out_data !== held_data)) stable_viol++;
    held_vld  = out_valid && !out_ready;
    held_data = out_data;
    if (rst) os = 0;
    else os = os - int'(out_valid && out_ready) + int'(re);
    if (os > max_os) max_os = os;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [OUT_W-1:0] ref_q(input logic [PSUM_W-1:0] raw, input logic [5:0] sh);
    longint v;
    v = $signed({{(64-PSUM_W){raw[PSUM_W-1]}}, raw});
`ifdef PSUM_DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    if (sh != 6'd0) v = v + (64'sd1 <<< (int'(sh) - 1));
    v = v >>> sh;
    if (v > QMAX) v = QMAX;
    else if (v < QMIN) v = QMIN;
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [LANES*OUT_W-1:0] ref_word(input logic [ADDR_W-1:0] a, input logic [5:0] sh);
    logic [LANES*OUT_W-1:0] w;
    logic [LANES*PSUM_W-1:0] m;
    m = mem[a];
    for (int k = 0; k < LANES; k++) w[k*OUT_W +: OUT_W] = ref_q(m[k*PSUM_W +: PSUM_W], sh);
    return w;
  endfunction

  task automatic fill_mem();
    logic signed [PSUM_W-1:0] v;
    for (int a = 0; a < 256; a++) begin
      for (int k = 0; k < LANES; k++) begin
        v = PSUM_W'({$urandom(), $urandom()});
        v = v >>> $urandom_range(0, 38);
        mem[a][k*PSUM_W +: PSUM_W] = v;
      end
    end
  endtask

  // Loads the scoreboard for a tile and pulses start for one cycle; returns in relative cycle 1.
  task automatic launch(input logic [7:0] base, input logic [7:0] tsz, input logic [5:0] sh);
    exp_ra.delete(); exp_beat.delete(); obs_ra.delete(); obs_beat.delete();
    obs_ra_cyc.delete(); obs_beat_cyc.delete();
    done_cnt = 0; max_os = 0; stable_viol = 0;
    for (int j = 0; j <= int'(tsz); j++) begin
      exp_ra.push_back(ADDR_W'(int'(base) + j));
      exp_beat.push_back(ref_word(ADDR_W'(int'(base) + j), sh));
    end
    @(posedge clk); #1;
    base_addr = base; tile_size = tsz; shift = sh; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives out_ready (0: always high, 1: low in relative cycles 3..10, else random) until done.
  task automatic run_until_done(input int mode, input int budget, output bit ok);
    int rel;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt != 0) begin ok = 1'b1; break; end
      rel = cyc - t0;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = !(rel >= 3 && rel <= 10);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (re !== 1'b0) begin n_fail++; $display("FAIL reset_re got %b want 0", re); end
    n_cmp++; if (ra !== '0) begin n_fail++; $display("FAIL reset_ra got %h want 00", ra); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    logic [ADDR_W-1:0] ga, ea;
    logic [LANES*OUT_W-1:0] gw, ew;
    int gc;
    mem[8'h10][PSUM_W-1:0] = 40'h0000001280;
    launch(8'h10, 8'd3, 6'd8);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    run_until_done(0, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    for (int j = 0; j < 4; j++) begin
      ea = exp_ra.pop_front();
      ga = (obs_ra.size() != 0) ? obs_ra.pop_front() : 'x;
      gc = (obs_ra_cyc.size() != 0) ? obs_ra_cyc.pop_front() - t0 : -1;
      n_cmp++; if (ga !== ea || gc != j + 1) begin n_fail++; $display("FAIL basic_ra[%0d] got %h@%0d want %h@%0d", j, ga, gc, ea, j + 1); end
    end
    for (int j = 0; j < 4; j++) begin
      ew = exp_beat.pop_front();
      gw = (obs_beat.size() != 0) ? obs_beat.pop_front() : 'x;
      gc = (obs_beat_cyc.size() != 0) ? obs_beat_cyc.pop_front() - t0 : -1;
      n_cmp++; if (gw !== ew || gc != j + 3) begin n_fail++; $display("FAIL basic_beat[%0d] got %h@%0d want %h@%0d", j, gw, gc, ew, j + 3); end
      if (j == 0) begin
        n_cmp++; if (gw[15:0] !== 16'h0013) begin n_fail++; $display("FAIL basic_lane0 got %h want 0013", gw[15:0]); end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (done_cyc - t0 != 7) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 7", done_cyc - t0); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", busy_at_done); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (obs_beat.size() != 0 || obs_ra.size() != 0) begin n_fail++; $display("FAIL basic_extra got %0d beats %0d reads want 0", obs_beat.size(), obs_ra.size()); end
  endtask

  task automatic test_quant();
    bit ok;
    logic [LANES*OUT_W-1:0] gw, ew;
    logic [OUT_W-1:0] neg_exp;
`ifdef PSUM_DRAIN_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif
    mem[8'h40] = {40'hFFFFFFFFFF, 40'h0000000000, 40'h8000000000, 40'h7FFFFFFFFF};
    launch(8'h40, 8'd0, 6'd4);
    run_until_done(0, 30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL quant_timeout got no done want done"); end
    n_cmp++; if (obs_ra.size() != 1) begin n_fail++; $display("FAIL quant_reads got %0d want 1", obs_ra.size()); end
    n_cmp++; if (obs_beat.size() != 1) begin n_fail++; $display("FAIL quant_beats got %0d want 1", obs_beat.size()); end
    ew = exp_beat.pop_front();
    gw = (obs_beat.size() != 0) ? obs_beat.pop_front() : 'x;
    n_cmp++; if (gw !== ew) begin n_fail++; $display("FAIL quant_word got %h want %h", gw, ew); end
    n_cmp++; if (gw[15:0] !== 16'h7FFF) begin n_fail++; $display("FAIL quant_pos_sat got %h want 7fff", gw[15:0]); end
    n_cmp++; if (gw[31:16] !== neg_exp) begin n_fail++; $display("FAIL quant_neg_sat got %h want %h", gw[31:16], neg_exp); end
  endtask

  task automatic test_shifts();
    bit ok;
    logic [LANES*OUT_W-1:0] gw, ew;
    logic [5:0] shs [4];
    shs = '{6'd0, 6'd1, 6'd13, 6'd39};
    for (int s = 0; s < 4; s++) begin
      launch(ADDR_W'(8'h50 + 8 * s), 8'd7, shs[s]);
      run_until_done(2, 200, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL shift%0d_timeout got no done want done", shs[s]); end
      while (exp_beat.size() != 0) begin
        ew = exp_beat.pop_front();
        gw = (obs_beat.size() != 0) ? obs_beat.pop_front() : 'x;
        n_cmp++; if (gw !== ew) begin n_fail++; $display("FAIL shift%0d_beat got %h want %h", shs[s], gw, ew); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [ADDR_W-1:0] ga, ea;
    logic [LANES*OUT_W-1:0] gw, ew;
    launch(8'h60, 8'd9, 6'd6);
    run_until_done(1, 200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got no done want done"); end
    n_cmp++; if (max_os > 2) begin n_fail++; $display("FAIL bp_outstanding got %0d want <=2", max_os); end
    n_cmp++; if (stable_viol != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stable_viol); end
    while (exp_ra.size() != 0) begin
      ea = exp_ra.pop_front();
      ga = (obs_ra.size() != 0) ? obs_ra.pop_front() : 'x;
      n_cmp++; if (ga !== ea) begin n_fail++; $display("FAIL bp_ra got %h want %h", ga, ea); end
    end
    while (exp_beat.size() != 0) begin
      ew = exp_beat.pop_front();
      gw = (obs_beat.size() != 0) ? obs_beat.pop_front() : 'x;
      n_cmp++; if (gw !== ew) begin n_fail++; $display("FAIL bp_beat got %h want %h", gw, ew); end
    end
    n_cmp++; if (obs_beat.size() != 0) begin n_fail++; $display("FAIL bp_extra_beats got %0d want 0", obs_beat.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [ADDR_W-1:0] ga, ea;
    logic [LANES*OUT_W-1:0] gw, ew;
    int nbeat;
    launch(8'hFE, 8'd3, 6'd8);
    run_until_done(0, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout got no done want done"); end
    n_cmp++; if (obs_ra.size() == 4 && obs_ra[2] !== 8'h00) begin n_fail++; $display("FAIL wrap_third_ra got %h want 00", obs_ra[2]); end
    while (exp_ra.size() != 0) begin
      ea = exp_ra.pop_front();
      ga = (obs_ra.size() != 0) ? obs_ra.pop_front() : 'x;
      n_cmp++; if (ga !== ea) begin n_fail++; $display("FAIL wrap_ra got %h want %h", ga, ea); end
    end
    launch(8'h80, 8'd255, 6'd10);
    run_until_done(2, 3000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_timeout got no done want done"); end
    n_cmp++; if (obs_beat.size() != 256) begin n_fail++; $display("FAIL full_beat_count got %0d want 256", obs_beat.size()); end
    n_cmp++; if (obs_ra.size() != 256) begin n_fail++; $display("FAIL full_read_count got %0d want 256", obs_ra.size()); end
    nbeat = 0;
    while (exp_beat.size() != 0) begin
      ew = exp_beat.pop_front();
      gw = (obs_beat.size() != 0) ? obs_beat.pop_front() : 'x;
      ea = exp_ra.pop_front();
      ga = (obs_ra.size() != 0) ? obs_ra.pop_front() : 'x;
      if (gw !== ew || ga !== ea) nbeat++;
    end
    n_cmp++; if (nbeat != 0) begin n_fail++; $display("FAIL full_sequence got %0d bad words want 0", nbeat); end
  endtask

  task automatic test_abort();
    bit ok;
    logic [LANES*OUT_W-1:0] gw, ew;
    launch(8'h20, 8'd9, 6'd5);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (obs_beat.size() >= 2) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_two_beats got %0d want 2", obs_beat.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (re !== 1'b0 || ra !== '0) begin n_fail++; $display("FAIL abort_read got re=%b ra=%h want 0", re, ra); end
    n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL abort_stream got v=%b d=%h want 0", out_valid, out_data); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_status got busy=%b done=%b want 0", busy, done); end
    @(posedge clk); #1;
    rst = 1'b0;
    obs_beat.delete(); obs_ra.delete();
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (obs_beat.size() != 0 || obs_ra.size() != 0) begin n_fail++; $display("FAIL abort_quiet got %0d beats %0d reads want 0", obs_beat.size(), obs_ra.size()); end
    launch(8'h90, 8'd4, 6'd7);
    run_until_done(0, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_restart_timeout got no done want done"); end
    n_cmp++; if (obs_ra.size() != 0 && obs_ra[0] !== 8'h90) begin n_fail++; $display("FAIL abort_restart_base got %h want 90", obs_ra[0]); end
    while (exp_beat.size() != 0) begin
      ew = exp_beat.pop_front();
      gw = (obs_beat.size() != 0) ? obs_beat.pop_front() : 'x;
      n_cmp++; if (gw !== ew) begin n_fail++; $display("FAIL abort_restart_beat got %h want %h", gw, ew); end
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    int rel;
    logic [ADDR_W-1:0] ga, ea;
    logic [LANES*OUT_W-1:0] gw, ew;
    launch(8'h30, 8'd5, 6'd3);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      rel = cyc - t0;
      start = (rel == 2 || rel == 4 || rel == 6) && (done_cnt == 0);
      base_addr = 8'hA0; tile_size = 8'd1; shift = 6'd20;
      @(posedge clk); #1;
      ok = (done_cnt != 0);
    end
    start = 1'b0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL busy_start_timeout got no done want done"); end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (obs_beat.size() != 6) begin n_fail++; $display("FAIL busy_start_beats got %0d want 6", obs_beat.size()); end
    while (exp_ra.size() != 0) begin
      ea = exp_ra.pop_front();
      ga = (obs_ra.size() != 0) ? obs_ra.pop_front() : 'x;
      n_cmp++; if (ga !== ea) begin n_fail++; $display("FAIL busy_start_ra got %h want %h", ga, ea); end
    end
    while (exp_beat.size() != 0) begin
      ew = exp_beat.pop_front();
      gw = (obs_beat.size() != 0) ? obs_beat.pop_front() : 'x;
      n_cmp++; if (gw !== ew) begin n_fail++; $display("FAIL busy_start_beat got %h want %h", gw, ew); end
    end
    n_cmp++; if (obs_ra.size() != 0) begin n_fail++; $display("FAIL busy_start_extra_reads got %0d want 0", obs_ra.size()); end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_basic();
    test_quant();
    test_shifts();
    test_backpressure();
    test_wrap();
    test_abort();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
